// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: runs the product motor, then ejects change one coin at a time,
// supervising each actuator with an acknowledge and a timeout and latching a sticky fault.
module vend_dispense_sequencer #(
  parameter int PULSE_W       = 4,
  parameter int GAP_W         = 2,
  parameter int MOTOR_TIMEOUT = 64,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_valid,
  input  logic [1:0] vend_pro,
  input  logic [2:0] vend_change,
  output logic       vend_ready,
  output logic       motor_on,
  output logic [1:0] motor_sel,
  input  logic       motor_done,
  output logic       coin_eject,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] remaining,
  input  logic       fault_clr
);

  localparam int MAX_A = (MOTOR_TIMEOUT > ACK_TIMEOUT) ? MOTOR_TIMEOUT : ACK_TIMEOUT;
  localparam int MAX_B = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    IDLE, MOTOR, EJECT, WAIT_ACK, GAP, DONE, FAULT
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ack_seen, ack_seen_n;
  logic [1:0]         pro_q, pro_n;
  logic [2:0]         rem_n;
  logic [1:0]         code_n;

  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ack_seen_n = ack_seen;
    pro_n      = pro_q;
    rem_n      = remaining;
    code_n     = fault_code;
    case (state)
      IDLE: begin
        if (vend_valid) begin
          pro_n      = vend_pro;
          rem_n      = vend_change;
          cnt_n      = '0;
          ack_seen_n = 1'b0;
          if (vend_pro != 2'b00)       state_n = MOTOR;
          else if (vend_change != 3'd0) state_n = EJECT;
          else                          state_n = DONE;
        end
      end
      MOTOR: begin
        // motor_done takes priority over a timeout landing on the same cycle
        if (motor_done) begin
          cnt_n      = '0;
          ack_seen_n = 1'b0;
          state_n    = (remaining != 3'd0) ? EJECT : DONE;
        end else if (cnt == CNT_W'(MOTOR_TIMEOUT - 1)) begin
          state_n = FAULT;
          code_n  = 2'b01;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EJECT: begin
        if (coin_ack) ack_seen_n = 1'b1;
        if (cnt == CNT_W'(PULSE_W - 1)) begin
          cnt_n = '0;
          // an ack arriving during the pulse credits this coin and skips WAIT_ACK
          if (ack_seen || coin_ack) begin
            ack_seen_n = 1'b0;
            rem_n      = dec_sat(remaining);
            state_n    = (remaining > 3'd1) ? GAP : DONE;
          end else begin
            state_n = WAIT_ACK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (coin_ack) begin
          cnt_n   = '0;
          rem_n   = dec_sat(remaining);
          state_n = (remaining > 3'd1) ? GAP : DONE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_n = FAULT;
          code_n  = 2'b10;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_W - 1)) begin
          cnt_n      = '0;
          ack_seen_n = 1'b0;
          state_n    = EJECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      FAULT: begin
        if (fault_clr) begin
          state_n = IDLE;
          code_n  = 2'b00;
          rem_n   = 3'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ack_seen   <= 1'b0;
      pro_q      <= 2'b00;
      remaining  <= 3'd0;
      fault_code <= 2'b00;
      vend_ready <= 1'b1;
      motor_on   <= 1'b0;
      motor_sel  <= 2'b00;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ack_seen   <= ack_seen_n;
      pro_q      <= pro_n;
      remaining  <= rem_n;
      fault_code <= code_n;
      vend_ready <= (state_n == IDLE);
      motor_on   <= (state_n == MOTOR);
      motor_sel  <= (state_n == MOTOR) ? pro_n : 2'b00;
      coin_eject <= (state_n == EJECT);
      busy       <= (state_n == MOTOR) || (state_n == EJECT) || (state_n == WAIT_ACK) ||
                    (state_n == GAP)   || (state_n == DONE);
      done       <= (state_n == DONE);
      fault      <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Directed bench for vend_dispense_sequencer with hand-computed expectations.
module tb_vend_dispense_sequencer;
  localparam int PULSE_W       = 4;
  localparam int GAP_W         = 2;
  localparam int MOTOR_TIMEOUT = 64;
  localparam int ACK_TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       vend_valid;
  logic [1:0] vend_pro;
  logic [2:0] vend_change;
  logic       vend_ready;
  logic       motor_on;
  logic [1:0] motor_sel;
  logic       motor_done;
  logic       coin_eject;
  logic       coin_ack;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] remaining;
  logic       fault_clr;

  int n_checks = 0;
  int n_pass   = 0;

  vend_dispense_sequencer #(
    .PULSE_W(PULSE_W), .GAP_W(GAP_W),
    .MOTOR_TIMEOUT(MOTOR_TIMEOUT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .vend_valid(vend_valid), .vend_pro(vend_pro),
    .vend_change(vend_change), .vend_ready(vend_ready), .motor_on(motor_on),
    .motor_sel(motor_sel), .motor_done(motor_done), .coin_eject(coin_eject),
    .coin_ack(coin_ack), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .remaining(remaining), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic order(input logic [1:0] pro, input logic [2:0] chg);
    vend_pro = pro; vend_change = chg; vend_valid = 1'b1;
    step(1);
    vend_valid = 1'b0;
  endtask

  // Called with the DUT in the first cycle of an eject pulse
  task automatic run_coin(input logic [2:0] rem_after, input bit last);
    int len;
    len = 0;
    while (coin_eject && len < 20) begin len++; step(1); end
    check("pulse_len", len, PULSE_W);
    check("eject_low_wait", coin_eject, 0);
    step(1);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;
    check("rem_dec", remaining, rem_after);
    if (last) begin
      check("done_pulse", done, 1);
      step(1);
      check("done_clear", done, 0);
      check("ready_again", vend_ready, 1);
    end else begin
      len = 0;
      while (!coin_eject && len < 20) begin len++; step(1); end
      check("gap_len", len, GAP_W);
    end
  endtask

  initial begin
    int len;
    reset = 1'b0; vend_valid = 1'b0; vend_pro = 2'b00; vend_change = 3'd0;
    motor_done = 1'b0; coin_ack = 1'b0; fault_clr = 1'b0;
    step(2);
    check("rst_ready", vend_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_motor", motor_on, 0);
    check("rst_eject", coin_eject, 0);
    check("rst_fault", fault, 0);
    check("rst_rem", remaining, 0);
    reset = 1'b1;
    step(1);

    // Product 01 with 3 coins of change
    order(2'b01, 3'd3);
    check("t1_motor_on", motor_on, 1);
    check("t1_motor_sel", motor_sel, 2'b01);
    check("t1_ready_low", vend_ready, 0);
    check("t1_rem_load", remaining, 3);
    check("t1_busy", busy, 1);
    step(4);
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
    check("t1_motor_off", motor_on, 0);
    check("t1_eject_on", coin_eject, 1);
    run_coin(3'd2, 1'b0);
    run_coin(3'd1, 1'b0);
    run_coin(3'd0, 1'b1);
    check("t1_idle_busy", busy, 0);

    // Empty order goes straight to DONE
    order(2'b00, 3'd0);
    check("t2_done", done, 1);
    check("t2_busy", busy, 1);
    check("t2_no_motor", motor_on, 0);
    check("t2_no_eject", coin_eject, 0);
    step(1);
    check("t2_busy_off", busy, 0);
    check("t2_done_off", done, 0);
    check("t2_ready", vend_ready, 1);

    // Motor never finishes
    order(2'b10, 3'd2);
    check("t3_sel", motor_sel, 2'b10);
    step(MOTOR_TIMEOUT - 1);
    check("t3_no_fault_yet", fault, 0);
    check("t3_motor_still", motor_on, 1);
    step(1);
    check("t3_fault", fault, 1);
    check("t3_code", fault_code, 2'b01);
    check("t3_rem", remaining, 2);
    check("t3_motor_off", motor_on, 0);
    check("t3_ready_low", vend_ready, 0);
    vend_valid = 1'b1; vend_pro = 2'b01; vend_change = 3'd1;
    step(3);
    vend_valid = 1'b0;
    check("t3_ignore_valid", fault, 1);
    check("t3_rem_frozen", remaining, 2);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("t3_clr_fault", fault, 0);
    check("t3_clr_code", fault_code, 0);
    check("t3_clr_rem", remaining, 0);
    check("t3_clr_ready", vend_ready, 1);

    // Third coin never acknowledged
    order(2'b00, 3'd4);
    check("t4_eject", coin_eject, 1);
    run_coin(3'd3, 1'b0);
    run_coin(3'd2, 1'b0);
    len = 0;
    while (coin_eject && len < 20) begin len++; step(1); end
    check("t4_pulse_len", len, PULSE_W);
    step(ACK_TIMEOUT - 1);
    check("t4_no_fault_yet", fault, 0);
    step(1);
    check("t4_fault", fault, 1);
    check("t4_code", fault_code, 2'b10);
    check("t4_rem", remaining, 2);
    check("t4_eject_off", coin_eject, 0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("t4_clr", fault, 0);

    // Reset in the middle of an eject pulse
    order(2'b00, 3'd3);
    run_coin(3'd2, 1'b0);
    step(1);
    check("t5_eject_mid", coin_eject, 1);
    check("t5_rem_mid", remaining, 2);
    reset = 1'b0;
    #1;
    check("t5_eject_abort", coin_eject, 0);
    check("t5_rem_abort", remaining, 0);
    check("t5_ready", vend_ready, 1);
    check("t5_no_done", done, 0);
    step(1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t5_no_done_after", done, 0);
    end

    // Motor done on the timeout cycle, acks during the pulse, duplicate and stray acks
    order(2'b01, 3'd2);
    step(MOTOR_TIMEOUT - 1);
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
    check("t6_no_fault", fault, 0);
    check("t6_eject", coin_eject, 1);
    coin_ack = 1'b1;
    step(2);
    coin_ack = 1'b0;
    step(1);
    check("t6_pulse_held", coin_eject, 1);
    check("t6_rem_held", remaining, 2);
    step(1);
    check("t6_gap_eject", coin_eject, 0);
    check("t6_rem_once", remaining, 1);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;
    check("t6_stray_ack", remaining, 1);
    step(1);
    check("t6_eject2", coin_eject, 1);
    step(PULSE_W - 1);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;
    check("t6_done", done, 1);
    check("t6_rem_zero", remaining, 0);
    check("t6_fault_none", fault, 0);
    step(1);
    check("t6_ready", vend_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
